// File: rtl/ff_fifo_stream_reader_if.sv
// Stream-reader bus bundle: show-ahead FIFO read port, valid/ready stream, flush and statistics.
// master = the drain engine, slave = the FIFO/consumer environment.
interface ff_fifo_stream_reader_if #(
  parameter int unsigned width       = 64,
  parameter int unsigned count_width = 32
);
  logic                   fifo_empty;
  logic [width-1:0]       fifo_read_data;
  logic                   fifo_pop;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [width-1:0]       out_data;
  logic [count_width-1:0] pop_count;
  logic [count_width-1:0] xfer_count;
  logic [count_width-1:0] stall_count;

  modport master (
    input  fifo_empty, fifo_read_data, flush, out_ready,
    output fifo_pop, out_valid, out_data, pop_count, xfer_count, stall_count
  );

  modport slave (
    output fifo_empty, fifo_read_data, flush, out_ready,
    input  fifo_pop, out_valid, out_data, pop_count, xfer_count, stall_count
  );
endinterface

// File: rtl/ff_fifo_stream_reader.sv
// Drains a show-ahead FIFO into a registered valid/ready stream via a 2-entry head/tail buffer.
// Define FIFO_RD_STATS_EN to build the pop/xfer/stall counters; otherwise they read 0.
module ff_fifo_stream_reader #(
  parameter int unsigned width       = 64,
  parameter int unsigned count_width = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  ff_fifo_stream_reader_if.master   bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;
  logic             out_valid;
  logic             fifo_pop;
  logic             load;
  logic             unload;

  // Pop depends only on registered state so out_ready never reaches the FIFO combinationally.
  assign out_valid = (state_q != ST_EMPTY);
  assign fifo_pop  = !bus.fifo_empty && (state_q != ST_TWO) && !bus.flush && !rst;
  assign load      = fifo_pop;
  assign unload    = out_valid && bus.out_ready;

  assign bus.fifo_pop  = fifo_pop;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (load) begin
            state_d = ST_ONE;
            head_d  = bus.fifo_read_data;
          end
        end
        ST_ONE: begin
          if (load && unload) begin
            head_d = bus.fifo_read_data;
          end else if (load) begin
            state_d = ST_TWO;
            tail_d  = bus.fifo_read_data;
          end else if (unload) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (unload) begin
            state_d = ST_ONE;
            head_d  = tail_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [count_width-1:0] pop_cnt_q, pop_cnt_d;
  logic [count_width-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [count_width-1:0] stall_cnt_q, stall_cnt_d;
  logic                   stall;

  // Counters wrap naturally; flush leaves them alone.
  assign stall = out_valid && !bus.out_ready;

  always_comb begin
    pop_cnt_d   = pop_cnt_q   + count_width'(load);
    xfer_cnt_d  = xfer_cnt_q  + count_width'(unload);
    stall_cnt_d = stall_cnt_q + count_width'(stall);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_cnt_q   <= '0;
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      pop_cnt_q   <= pop_cnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pop_count   = pop_cnt_q;
  assign bus.xfer_count  = xfer_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.pop_count   = '0;
  assign bus.xfer_count  = '0;
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_ff_fifo_stream_reader.sv
// Scoreboard bench for ff_fifo_stream_reader: queue-based FIFO and in-flight word model,
// directed phases followed by randomized traffic, flush and reset.
module tb_ff_fifo_stream_reader;
  localparam int unsigned W  = 64;
  localparam int unsigned CW = 4;

  logic clk;
  logic rst;

  ff_fifo_stream_reader_if #(.width(W), .count_width(CW)) bus ();

  ff_fifo_stream_reader #(.width(W), .count_width(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] fifo_m[$];
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;
  int n_hs   = 0;
  int n_stall = 0;
  int m_pops = 0, m_xfers = 0, m_stalls = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares DUT outputs against the in-flight word model each cycle.
  always @(negedge clk) begin
    logic exp_pop;
    logic hs;
    #1;
    exp_pop = (fifo_m.size() != 0) && (exp_q.size() < 2) && !bus.flush && !rst;
    chk("fifo_pop", 64'(bus.fifo_pop), 64'(exp_pop));
    chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_data", 64'(bus.out_data), 64'(exp_q[0]));
`ifdef FIFO_RD_STATS_EN
    chk("pop_count", 64'(bus.pop_count), 64'(CW'(m_pops)));
    chk("xfer_count", 64'(bus.xfer_count), 64'(CW'(m_xfers)));
    chk("stall_count", 64'(bus.stall_count), 64'(CW'(m_stalls)));
`else
    chk("pop_count", 64'(bus.pop_count), 64'd0);
    chk("xfer_count", 64'(bus.xfer_count), 64'd0);
    chk("stall_count", 64'(bus.stall_count), 64'd0);
`endif
    hs = bus.out_valid && bus.out_ready;
    if (hs) n_hs++;
    if (bus.out_valid && !bus.out_ready) n_stall++;
    if (hs && exp_q.size() != 0) void'(exp_q.pop_front());
    if (rst) begin
      m_pops = 0; m_xfers = 0; m_stalls = 0;
    end else begin
      m_pops   += int'(exp_pop);
      m_xfers  += int'(exp_q.size() >= 0 && hs);
      m_stalls += int'(bus.out_valid && !bus.out_ready);
    end
    if (bus.flush || rst) exp_q.delete();
  end

  // Drive one cycle at the falling edge; record the popped word once fifo_pop has settled.
  task automatic cycle(input logic r, input logic f, input logic rdy);
    @(negedge clk);
    rst            = r;
    bus.flush      = f;
    bus.out_ready  = rdy;
    bus.fifo_empty = (fifo_m.size() == 0);
    bus.fifo_read_data = (fifo_m.size() == 0) ? '0 : fifo_m[0];
    #2;
    if (bus.fifo_pop && fifo_m.size() != 0) exp_q.push_back(fifo_m.pop_front());
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_read_data = '0;

    // Reset with words waiting in the FIFO
    for (int i = 1; i <= 3; i++) fifo_m.push_back(W'(i));
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("reset_out_data", 64'(bus.out_data), 64'd0);
    chk("first_pop", 64'(bus.fifo_pop), 64'd1);
    cycle(1'b0, 1'b0, 1'b1);
    chk("first_latency", 64'(bus.out_valid), 64'd1);
    repeat (6) cycle(1'b0, 1'b0, 1'b1);

    // Streaming
    for (int i = 16; i < 32; i++) fifo_m.push_back(W'(i));
    base = n_hs;
    repeat (20) cycle(1'b0, 1'b0, 1'b1);
    chk("stream_xfers", 64'(n_hs - base), 64'd16);

    // Back-pressure for cycles 3..8
    for (int i = 32; i < 48; i++) fifo_m.push_back(W'(i));
    base = n_stall;
    for (int i = 0; i < 26; i++) cycle(1'b0, 1'b0, !(i >= 3 && i <= 8));
    chk("bp_stalls", 64'(n_stall - base), 64'd6);

    // Single word then empty
    fifo_m.push_back(W'(8'hAA));
    base = n_hs;
    repeat (6) cycle(1'b0, 1'b0, 1'b1);
    chk("empty_xfers", 64'(n_hs - base), 64'd1);

    // Flush while holding A and B; C stays in the FIFO
    fifo_m.push_back(W'(8'hA0));
    fifo_m.push_back(W'(8'hB0));
    fifo_m.push_back(W'(8'hC0));
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    base = n_hs;
    cycle(1'b0, 1'b1, 1'b1);
    chk("flush_hs", 64'(n_hs - base), 64'd1);
    chk("flush_no_pop", 64'(bus.fifo_pop), 64'd0);
    repeat (5) cycle(1'b0, 1'b0, 1'b1);
    chk("flush_then_c", 64'(n_hs - base), 64'd2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && fifo_m.size() < 8)
        fifo_m.push_back({$urandom(), $urandom()});
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (20) cycle(1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/ff_fifo_stream_reader.md
# ff_fifo_stream_reader

Read-side drain engine for the team's push/pop FIFOs. Pops a show-ahead FIFO (combinational `read_data` valid whenever `empty` is low) and presents the words on a registered valid/ready stream. A 2-entry output buffer sustains one word per cycle while keeping `out_ready` off the combinational path to the FIFO `pop`. It sits between any `ff_fifo_*` instance and a valid/ready consumer.

## Interface
- `width`, 64, data word width; must match the attached FIFO.
- `count_width`, 32, width of statistics counters.

- `clk`  in  1  clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_read_data`  in  width  FIFO head word, valid when `fifo_empty`=0.
- `fifo_pop`  out  1  pops the FIFO head this cycle.
- `flush`  in  1  synchronous buffer clear; no FIFO pop in that cycle.
- `out_valid`  out  1  stream word available.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  width  stream word.
- `pop_count`  out  count_width  number of FIFO pops.
- `xfer_count`  out  count_width  number of completed stream transfers.
- `stall_count`  out  count_width  number of cycles with `out_valid` high and `out_ready` low.

## Operation
- Storage is two registers, `head` and `tail`. State is EMPTY, ONE or TWO. `out_data` = `head`; `out_valid` = (state != EMPTY), decoded from the registered state only.
- `fifo_pop` = !`fifo_empty` & (state != TWO) & !`flush` & !`rst`. It never depends on `out_ready`.
- `load` = `fifo_pop`. `unload` = `out_valid` & `out_ready`.
- EMPTY:
  - On load, go to ONE and `head` <= `fifo_read_data`.
- ONE:
  - On load & unload, stay in ONE and `head` <= `fifo_read_data`.
  - On load only, go to TWO and `tail` <= `fifo_read_data`.
  - On unload only, go to EMPTY.
- TWO:
  - Load cannot occur.
  - On unload, go to ONE and `head` <= `tail`.
- Stream rule: while `out_valid` & !`out_ready`, `out_valid` stays 1 and `out_data` holds. The only exception is `flush`.
- `flush`:
  - Next state is EMPTY and buffered words are discarded.
  - A handshake in the flush cycle still completes and is counted.
  - FIFO contents are untouched.
  - `flush` takes priority over load and unload for the state update.
- Counters:
  - `pop_count` +1 per `fifo_pop`.
  - `xfer_count` +1 per unload.
  - `stall_count` +1 per stall cycle.
  - All wrap modulo 2^count_width.
  - Cleared by `rst` only; not by `flush`.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `out_data` 0, `head`/`tail` 0, all counters 0, `fifo_pop` 0 during `rst`.
- Latency: FIFO non-empty at cycle N (pop at N) gives `out_valid` high at N+1 with that word.
- Throughput: with `out_ready` held high and the FIFO non-empty, state stays in ONE and the block moves 1 word per cycle.
- Back-pressure: after `out_ready` drops, at most one further pop (ONE to TWO) occurs, then `fifo_pop` stays low.
- `out_ready` rising in TWO: unload at cycle M, pop resumes at M+1.
- Order: words leave in exact FIFO pop order; none lost or duplicated except by `flush`.
- `rst` mid-operation: applied at the next edge, same values as reset. Buffered words are dropped.

## Configuration
- `FIFO_RD_STATS_EN` defined: the three counters are implemented as specified.
- Not defined: `pop_count`, `xfer_count` and `stall_count` are tied to 0 and no counter flops exist. All other behaviour is identical.

## Test plan
- **Reset and idle:** assert `rst` 2 cycles with the FIFO holding 3 words. Required: `fifo_pop`=0 and `out_valid`=0 during reset; after reset, first `out_valid` comes 1 cycle after the first pop.
- **Streaming:** FIFO preloaded with 0x10..0x1F, `out_ready`=1. Required: 16 consecutive transfers 0x10..0x1F, one per cycle; `pop_count`=`xfer_count`=16.
- **Back-pressure:** as above, but `out_ready`=0 for cycles 3..8. Required: exactly 2 words buffered, `fifo_pop` low while in TWO, `out_data` stable, `stall_count`=6, no loss or reorder.
- **Empty boundary:** FIFO gets a single word 0xAA, then goes empty. Required: one transfer of 0xAA; then `out_valid`=0 and `fifo_pop`=0 while empty.
- **Flush:** `flush` in state TWO (words A, B) with `out_ready`=1. Required: A transferred and counted, B dropped, next state EMPTY, no pop in the flush cycle, counters not cleared.
- **Wrap (`count_width`=4, `FIFO_RD_STATS_EN` defined):** 18 transfers. Required: `xfer_count`=2. Built without the macro, all counters read 0.
